// File: rtl/ksa_sub_pipe.sv
// Two-stage pipelined subtractor: diff = a + ~b + 1 with Kogge-Stone carries.
// Stage 1 registers generate/propagate, stage 2 registers the prefix result and flags.
module ksa_sub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);

    logic             s1_valid, s2_valid;
    logic             accept, adv2;
    logic [WIDTH-1:0] g_d, p_d, g_q, p_q;
    logic [WIDTH-1:0] gk [0:LEVELS];
    logic [WIDTH-1:0] pk [0:LEVELS-1];
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] diff_d, diff_q;
    logic             borrow_d, ovf_d, zero_d;
    logic             borrow_q, ovf_q, zero_q;

    assign adv2     = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | adv2;
    assign accept   = in_valid & in_ready;

    // Carry-in of 1 is folded into bit 0 so the prefix network needs no extra input.
    always_comb begin
        p_d    = a ^ ~b;
        g_d    = a & ~b;
        g_d[0] = g_d[0] | p_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            g_q      <= '0;
            p_q      <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            g_q      <= g_d;
            p_q      <= p_d;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Each level combines the group ending at bit i with the one 2^k bits below it.
    always_comb begin
        gk[0] = g_q;
        pk[0] = p_q;
        for (int k = 0; k < LEVELS - 1; k++) begin
            gk[k+1] = gk[k] | (pk[k] & (gk[k] << (1 << k)));
            pk[k+1] = pk[k] & ((pk[k] << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
        end
        gk[LEVELS] = gk[LEVELS-1]
                   | (pk[LEVELS-1] & (gk[LEVELS-1] << (1 << (LEVELS - 1))));
    end

    always_comb begin
        c        = gk[LEVELS];
        diff_d   = p_q ^ {c[WIDTH-2:0], 1'b1};
        borrow_d = ~c[WIDTH-1];
        ovf_d    = c[WIDTH-1] ^ c[WIDTH-2];
        zero_d   = (diff_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= 1'b1;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Self-checking bench for ksa_sub_pipe at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_ksa_sub_pipe;

    localparam int NRAND = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8, ir8, ov8, ordy8, br8, of8, z8;
    logic [7:0]  a8, b8, d8;
    logic        iv16, ir16, ov16, ordy16, br16, of16, z16;
    logic [15:0] a16, b16, d16;

    int n_checks = 0;
    int n_pass   = 0;

    ksa_sub_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(ordy8), .diff(d8), .borrow(br8), .ovf(of8), .zero(z8)
    );

    ksa_sub_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(ordy16), .diff(d16), .borrow(br16), .ovf(of16),
        .zero(z16)
    );

    // Packed as {diff, borrow, ovf, zero}.
    function automatic logic [10:0] model8(input logic [7:0] x, input logic [7:0] y);
        int sx, sy, r;
        logic [7:0] d;
        d  = x - y;
        sx = $signed(x);
        sy = $signed(y);
        r  = sx - sy;
        return {d, x < y, (r > 127) || (r < -128), d == 8'h00};
    endfunction

    function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y);
        int sx, sy, r;
        logic [15:0] d;
        d  = x - y;
        sx = $signed(x);
        sy = $signed(y);
        r  = sx - sy;
        return {d, x < y, (r > 32767) || (r < -32768), d == 16'h0000};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; ordy8 = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; ordy16 = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ov8, d8, br8, of8, z8} !== 12'h000)
            $display("FAIL reset8 got=%h exp=000", {ov8, d8, br8, of8, z8});
        else n_pass++;
        n_checks++;
        if ({ov16, d16, br16, of16, z16} !== 20'h00000)
            $display("FAIL reset16 got=%h exp=00000", {ov16, d16, br16, of16, z16});
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ir8, ir16, ov8, ov16} !== 4'b1100)
            $display("FAIL reset_release got=%b exp=1100", {ir8, ir16, ov8, ov16});
        else n_pass++;
    endtask

    task automatic single8(input string name, input logic [7:0] x, input logic [7:0] y,
                           input logic [10:0] exp);
        int w;
        @(posedge clk); #1;
        a8 = x; b8 = y; iv8 = 1'b1; ordy8 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ir8 !== 1'b1) $display("FAIL %s_in_ready got=%b exp=1", name, ir8);
        else n_pass++;
        @(posedge clk); #1 iv8 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ov8 !== 1'b0) $display("FAIL %s_early_valid got=%b exp=0", name, ov8);
        else n_pass++;
        w = 0;
        while (ov8 !== 1'b1 && w < 4) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (ov8 !== 1'b1 || {d8, br8, of8, z8} !== exp)
            $display("FAIL %s got v=%b d/b/o/z=%h exp v=1 %h", name, ov8,
                     {d8, br8, of8, z8}, exp);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ov8 !== 1'b0) $display("FAIL %s_single got v=%b exp=0", name, ov8);
        else n_pass++;
    endtask

    task automatic test_basic;
        single8("basic", 8'h05, 8'h03, {8'h02, 3'b000});
    endtask

    task automatic test_underflow_zero;
        single8("underflow", 8'h03, 8'h05, {8'hFE, 3'b100});
        single8("zero", 8'h7A, 8'h7A, {8'h00, 3'b001});
    endtask

    task automatic test_signed_ovf;
        single8("ovf_neg", 8'h80, 8'h01, {8'h7F, 3'b010});
        single8("ovf_pos", 8'h7F, 8'hFF, {8'h80, 3'b110});
    endtask

    task automatic test_backpressure;
        logic [7:0]  xa [4];
        logic [7:0]  xb [4];
        logic [10:0] exp [4];
        int acc, nout, first, last;
        for (int i = 0; i < 4; i++) begin
            xa[i]  = 8'($urandom);
            xb[i]  = 8'($urandom);
            exp[i] = model8(xa[i], xb[i]);
        end
        acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            ordy8 = 1'b0;
            iv8 = (acc < 4);
            if (acc < 4) begin a8 = xa[acc]; b8 = xb[acc]; end
            @(negedge clk);
            if (iv8 && ir8) acc++;
        end
        n_checks++;
        if (acc != 2 || ir8 !== 1'b0)
            $display("FAIL bp_stall got acc=%0d in_ready=%b exp acc=2 in_ready=0", acc, ir8);
        else n_pass++;
        n_checks++;
        if (ov8 !== 1'b1 || {d8, br8, of8, z8} !== exp[0])
            $display("FAIL bp_hold got v=%b %h exp v=1 %h", ov8, {d8, br8, of8, z8}, exp[0]);
        else n_pass++;
        nout = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            ordy8 = 1'b1;
            iv8 = (acc < 4);
            if (acc < 4) begin a8 = xa[acc]; b8 = xb[acc]; end
            @(negedge clk);
            if (iv8 && ir8) acc++;
            if (ov8) begin
                n_checks++;
                if (nout >= 4) $display("FAIL bp_extra got result %0d exp none", nout);
                else if ({d8, br8, of8, z8} !== exp[nout])
                    $display("FAIL bp_order%0d got %h exp %h", nout, {d8, br8, of8, z8},
                             exp[nout]);
                else n_pass++;
                if (first < 0) first = cyc;
                last = cyc;
                nout++;
            end
        end
        iv8 = 1'b0;
        n_checks++;
        if (nout != 4 || last - first != 3)
            $display("FAIL bp_drain got n=%0d span=%0d exp n=4 span=3", nout, last - first);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int acc, stale;
        acc = 0;
        for (int cyc = 0; cyc < 4 && acc < 2; cyc++) begin
            @(posedge clk); #1;
            ordy8 = 1'b0; iv8 = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            if (ir8) acc++;
        end
        @(posedge clk); #2;
        iv8 = 1'b0;
        n_checks++;
        if (ov8 !== 1'b1) $display("FAIL rmid_prefill got v=%b exp=1", ov8);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov8, d8} !== 9'h000) $display("FAIL rmid_async got %h exp 000", {ov8, d8});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1; ordy8 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ir8 !== 1'b1) $display("FAIL rmid_ready got %b exp 1", ir8);
        else n_pass++;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (ov8 !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) $display("FAIL rmid_stale got %0d exp 0", stale);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [10:0] q8 [$];
        logic [18:0] q16 [$];
        logic [10:0] held8, e8;
        logic [18:0] held16, e16;
        int acc8, acc16, cyc;
        bit pend8, pend16, stall8, stall16;
        acc8 = 0; acc16 = 0; cyc = 0;
        pend8 = 0; pend16 = 0; stall8 = 0; stall16 = 0;
        held8 = '0; held16 = '0;
        while ((acc8 < NRAND || acc16 < NRAND || q8.size() != 0 || q16.size() != 0)
               && cyc < 40000) begin
            @(posedge clk); #1;
            ordy8  = ($urandom_range(3) != 0);
            ordy16 = ($urandom_range(3) != 0);
            if (!pend8) begin
                iv8 = (acc8 < NRAND) && ($urandom_range(3) != 0);
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            if (!pend16) begin
                iv16 = (acc16 < NRAND) && ($urandom_range(3) != 0);
                a16 = 16'($urandom); b16 = 16'($urandom);
            end
            @(negedge clk);
            if (stall8) begin
                n_checks++;
                if (ov8 !== 1'b1 || {d8, br8, of8, z8} !== held8)
                    $display("FAIL rnd8_hold got v=%b %h exp v=1 %h", ov8, {d8, br8, of8, z8},
                             held8);
                else n_pass++;
            end
            if (stall16) begin
                n_checks++;
                if (ov16 !== 1'b1 || {d16, br16, of16, z16} !== held16)
                    $display("FAIL rnd16_hold got v=%b %h exp v=1 %h", ov16,
                             {d16, br16, of16, z16}, held16);
                else n_pass++;
            end
            stall8  = ov8 && !ordy8;
            stall16 = ov16 && !ordy16;
            held8   = {d8, br8, of8, z8};
            held16  = {d16, br16, of16, z16};
            if (iv8 && ir8) begin
                q8.push_back(model8(a8, b8));
                acc8++;
                pend8 = 0;
            end else pend8 = iv8;
            if (iv16 && ir16) begin
                q16.push_back(model16(a16, b16));
                acc16++;
                pend16 = 0;
            end else pend16 = iv16;
            if (ov8 && ordy8) begin
                n_checks++;
                if (q8.size() == 0) $display("FAIL rnd8_spurious got %h exp none", held8);
                else begin
                    e8 = q8.pop_front();
                    if (held8 !== e8) $display("FAIL rnd8 got %h exp %h", held8, e8);
                    else n_pass++;
                end
            end
            if (ov16 && ordy16) begin
                n_checks++;
                if (q16.size() == 0) $display("FAIL rnd16_spurious got %h exp none", held16);
                else begin
                    e16 = q16.pop_front();
                    if (held16 !== e16) $display("FAIL rnd16 got %h exp %h", held16, e16);
                    else n_pass++;
                end
            end
            cyc++;
        end
        iv8 = 1'b0; iv16 = 1'b0;
        n_checks++;
        if (acc8 != NRAND || acc16 != NRAND || q8.size() != 0 || q16.size() != 0)
            $display("FAIL rnd_complete got acc=%0d/%0d left=%0d/%0d exp acc=%0d left=0",
                     acc8, acc16, q8.size(), q16.size(), NRAND);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow_zero();
        test_signed_ovf();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
